sram_access_arbiter: RTL and testbench

Shares the single 8-bit external SRAM between three requesters: the ROM/disk-image download port (ioctl), the CGA video fetch engine, and the CPU/DMA system bus. It grants one access at a time through a fixed-length SRAM cycle sequencer. It drives the SRAM address, data and write-enable pins. Its `bus_ready` output is ANDed into the chipset's I/O-channel-ready term so that bus cycles stretch until served.

---
 rtl/sram_access_arbiter.sv | 168 ++++++++++++++++
 tb/tb_sram_access_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_access_arbiter.sv
// rtl/sram_access_arbiter.sv - three-way arbiter and fixed-length cycle sequencer for the shared 8-bit SRAM
//
// Ports:
//   clock, reset_n                      single rising-edge clock, async active-low reset
//   dl_req/dl_addr/dl_data/dl_ack       download port (writes only)
//   vid_req/vid_addr/vid_data/vid_ack   video fetch port (reads only)
//   bus_rd_req/bus_wr_req/bus_addr/bus_wdata/bus_rdata/bus_ack
//                                       CPU/DMA bus port (read or write)
//   bus_ready                           low while a bus request waits for its ack
//   sram_addr/sram_dout/sram_din        SRAM address and data pins
//   sram_oe                             1 = drive sram_dout onto the SRAM data pins
//   sram_we_n                           SRAM write strobe, active-low

module sram_access_arbiter #(
    parameter int ADDR_WIDTH    = 21,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  dl_req,
    input  logic [ADDR_WIDTH-1:0] dl_addr,
    input  logic [7:0]            dl_data,
    output logic                  dl_ack,
    input  logic                  vid_req,
    input  logic [ADDR_WIDTH-1:0] vid_addr,
    output logic [7:0]            vid_data,
    output logic                  vid_ack,
    input  logic                  bus_rd_req,
    input  logic                  bus_wr_req,
    input  logic [ADDR_WIDTH-1:0] bus_addr,
    input  logic [7:0]            bus_wdata,
    output logic [7:0]            bus_rdata,
    output logic                  bus_ack,
    output logic                  bus_ready,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [7:0]            sram_dout,
    input  logic [7:0]            sram_din,
    output logic                  sram_oe,
    output logic                  sram_we_n
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACCESS  = 2'd1;
    localparam logic [1:0] ST_RECOVER = 2'd2;

    localparam logic [1:0] G_DL  = 2'd0;
    localparam logic [1:0] G_VID = 2'd1;
    localparam logic [1:0] G_BUS = 2'd2;

    localparam logic [3:0] LAST_CYCLE = 4'(ACCESS_CYCLES);

    logic [1:0] state;
    logic [1:0] grant;
    logic [3:0] cnt;
    logic       bus_skipped;
    logic       lat_wr;

    logic                  bus_req;
    logic                  any_req;
    logic [1:0]            pick;
    logic [ADDR_WIDTH-1:0] pick_addr;
    logic [7:0]            pick_data;
    logic                  pick_wr;

    assign bus_req   = bus_rd_req | bus_wr_req;
    assign any_req   = dl_req | vid_req | bus_req;
    assign bus_ready = ~bus_req | bus_ack;

    // dl always wins; the bus beats video only when it was passed over last time
    // or video is not asking.
    always_comb begin
        pick      = G_DL;
        pick_addr = dl_addr;
        pick_data = dl_data;
        pick_wr   = 1'b1;
        if (dl_req) begin
            pick      = G_DL;
            pick_addr = dl_addr;
            pick_data = dl_data;
            pick_wr   = 1'b1;
        end else if (bus_req && (bus_skipped || !vid_req)) begin
            pick      = G_BUS;
            pick_addr = bus_addr;
            pick_data = bus_wdata;
            pick_wr   = bus_wr_req;
        end else if (vid_req) begin
            pick      = G_VID;
            pick_addr = vid_addr;
            pick_data = 8'h00;
            pick_wr   = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            grant       <= G_DL;
            cnt         <= 4'd0;
            bus_skipped <= 1'b0;
            lat_wr      <= 1'b0;
            dl_ack      <= 1'b0;
            vid_ack     <= 1'b0;
            bus_ack     <= 1'b0;
            vid_data    <= 8'h00;
            bus_rdata   <= 8'h00;
            sram_addr   <= '0;
            sram_dout   <= 8'h00;
            sram_oe     <= 1'b0;
            sram_we_n   <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        state     <= ST_ACCESS;
                        cnt       <= 4'd1;
                        grant     <= pick;
                        lat_wr    <= pick_wr;
                        sram_addr <= pick_addr;
                        if (pick_wr) begin
                            sram_dout <= pick_data;
                        end
                        // Access cycle 1 is always a strobe cycle for writes,
                        // since the sequence is at least two cycles long.
                        sram_oe   <= pick_wr;
                        sram_we_n <= ~pick_wr;
                        if (pick == G_VID && bus_req) begin
                            bus_skipped <= 1'b1;
                        end else if (pick == G_BUS) begin
                            bus_skipped <= 1'b0;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (cnt == LAST_CYCLE) begin
                        state     <= ST_RECOVER;
                        cnt       <= 4'd0;
                        sram_oe   <= 1'b0;
                        sram_we_n <= 1'b1;
                        if (!lat_wr && grant == G_VID) begin
                            vid_data <= sram_din;
                        end
                        if (!lat_wr && grant == G_BUS) begin
                            bus_rdata <= sram_din;
                        end
                        dl_ack  <= (grant == G_DL);
                        vid_ack <= (grant == G_VID);
                        bus_ack <= (grant == G_BUS);
                    end else begin
                        cnt <= cnt + 4'd1;
                        // Release the strobe for the final cycle so address and
                        // data stay stable past its rising edge.
                        sram_we_n <= ~(lat_wr && ((cnt + 4'd1) < LAST_CYCLE));
                    end
                end
                ST_RECOVER: begin
                    state   <= ST_IDLE;
                    dl_ack  <= 1'b0;
                    vid_ack <= 1'b0;
                    bus_ack <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_access_arbiter.sv
// tb/tb_sram_access_arbiter.sv - directed scoreboard bench for sram_access_arbiter

module tb_sram_access_arbiter;

    localparam int AW = 21;

    logic          clock;
    logic          reset_n;
    logic          dl_req;
    logic [AW-1:0] dl_addr;
    logic [7:0]    dl_data;
    logic          dl_ack;
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic [7:0]    vid_data;
    logic          vid_ack;
    logic          bus_rd_req;
    logic          bus_wr_req;
    logic [AW-1:0] bus_addr;
    logic [7:0]    bus_wdata;
    logic [7:0]    bus_rdata;
    logic          bus_ack;
    logic          bus_ready;
    logic [AW-1:0] sram_addr;
    logic [7:0]    sram_dout;
    logic [7:0]    sram_din;
    logic          sram_oe;
    logic          sram_we_n;

    sram_access_arbiter #(.ADDR_WIDTH(AW), .ACCESS_CYCLES(2)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .dl_req     (dl_req),
        .dl_addr    (dl_addr),
        .dl_data    (dl_data),
        .dl_ack     (dl_ack),
        .vid_req    (vid_req),
        .vid_addr   (vid_addr),
        .vid_data   (vid_data),
        .vid_ack    (vid_ack),
        .bus_rd_req (bus_rd_req),
        .bus_wr_req (bus_wr_req),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .bus_ack    (bus_ack),
        .bus_ready  (bus_ready),
        .sram_addr  (sram_addr),
        .sram_dout  (sram_dout),
        .sram_din   (sram_din),
        .sram_oe    (sram_oe),
        .sram_we_n  (sram_we_n)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // SRAM model: 4K window on the low address bits, preloaded with a pattern.
    logic [7:0] mem [0:4095];
    assign sram_din = mem[sram_addr[11:0]];

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'(i) ^ 8'h5C;
        mem[12'h800] = 8'hC3;
        mem[12'h123] = 8'h7E;
        forever begin
            @(posedge clock);
            if (!sram_we_n && sram_oe) mem[sram_addr[11:0]] = sram_dout;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [2:0] ack_vec;
        logic       is_read;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    task automatic push(input logic [2:0] v, input logic rd, input logic [7:0] d);
        exp_t e;
        e.ack_vec = v;
        e.is_read = rd;
        e.data    = d;
        sb.push_back(e);
    endtask

    // Every ack pops the oldest expected access and checks its source and read data.
    always @(negedge clock) begin
        if (dl_ack | vid_ack | bus_ack) begin
            if (sb.size() == 0) begin
                check("unexpected_ack", {dl_ack, vid_ack, bus_ack}, 3'b000);
            end else begin
                mon_e = sb.pop_front();
                check("ack_src", {dl_ack, vid_ack, bus_ack}, mon_e.ack_vec);
                if (mon_e.is_read && mon_e.ack_vec == 3'b010) check("sb_vid_data", vid_data, mon_e.data);
                if (mon_e.is_read && mon_e.ack_vec == 3'b001) check("sb_bus_rdata", bus_rdata, mon_e.data);
            end
        end
    end

    logic [3:0] we_h, oe_h, ack_h, rdy_h;
    int         c0, n;
    logic       got;

    initial begin
        reset_n = 1'b0;
        dl_req = 1'b0; dl_addr = '0; dl_data = 8'h00;
        vid_req = 1'b0; vid_addr = '0;
        bus_rd_req = 1'b0; bus_wr_req = 1'b0; bus_addr = '0; bus_wdata = 8'h00;

        // Reset values
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_we_n", sram_we_n, 1'b1);
        check("rst_oe", sram_oe, 1'b0);
        check("rst_addr", sram_addr, 0);
        check("rst_dout", sram_dout, 8'h00);
        check("rst_vid_data", vid_data, 8'h00);
        check("rst_bus_rdata", bus_rdata, 8'h00);
        check("rst_acks", {dl_ack, vid_ack, bus_ack}, 3'b000);
        check("rst_ready", bus_ready, 1'b1);
        check("rst_skip", dut.bus_skipped, 1'b0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("idle_oe", sram_oe, 1'b0);
            check("idle_ready", bus_ready, 1'b1);
        end

        // Single bus write
        @(posedge clock); #1;
        bus_wr_req = 1'b1; bus_addr = 21'h1ABCD; bus_wdata = 8'h5A;
        push(3'b001, 1'b0, 8'h00);
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            we_h[c] = sram_we_n; oe_h[c] = sram_oe; ack_h[c] = bus_ack; rdy_h[c] = bus_ready;
            if (c == 1) begin
                check("wr_addr", sram_addr, 21'h1ABCD);
                check("wr_dout", sram_dout, 8'h5A);
            end
        end
        bus_wr_req = 1'b0;
        check("wr_we_n", we_h, 4'b1101);
        check("wr_oe", oe_h, 4'b0110);
        check("wr_ack", ack_h, 4'b1000);
        check("wr_ready", rdy_h, 4'b1000);
        @(posedge clock); #1;
        check("wr_mem", mem[12'hBCD], 8'h5A);

        // Video read
        vid_req = 1'b1; vid_addr = 21'h0B800;
        push(3'b010, 1'b1, 8'hC3);
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            ack_h[c] = vid_ack;
            if (c == 3) begin
                check("vid_data", vid_data, 8'hC3);
                check("vid_bus_rdata_kept", bus_rdata, 8'h00);
            end
        end
        vid_req = 1'b0;
        check("vid_ack", ack_h, 4'b1000);
        @(posedge clock); #1;

        // vid and bus held together: grants alternate, one access per 4 cycles
        c0 = cyc; n = 0;
        vid_req = 1'b1; vid_addr = 21'h0B800;
        bus_rd_req = 1'b1; bus_addr = 21'h00123;
        push(3'b010, 1'b1, 8'hC3);
        push(3'b001, 1'b1, 8'h7E);
        push(3'b010, 1'b1, 8'hC3);
        push(3'b001, 1'b1, 8'h7E);
        for (int i = 0; i < 40 && n < 4; i++) begin
            @(negedge clock);
            if (vid_ack | bus_ack) begin
                check("alt_ack_cycle", cyc - c0, 3 + 4 * n);
                n++;
            end
        end
        vid_req = 1'b0; bus_rd_req = 1'b0;
        check("alt_count", n, 4);
        @(posedge clock); #1;

        // dl, vid and bus write together: dl, then vid, then bus
        dl_req = 1'b1; dl_addr = 21'h00200; dl_data = 8'h11;
        vid_req = 1'b1; vid_addr = 21'h0B800;
        bus_wr_req = 1'b1; bus_addr = 21'h00300; bus_wdata = 8'h22;
        push(3'b100, 1'b0, 8'h00);
        push(3'b010, 1'b1, 8'hC3);
        push(3'b001, 1'b0, 8'h00);
        for (int i = 0; i < 40 && (dl_req | vid_req | bus_wr_req); i++) begin
            @(negedge clock);
            if (dl_ack) dl_req = 1'b0;
            if (vid_ack) begin
                vid_req = 1'b0;
                check("skip_after_vid", dut.bus_skipped, 1'b1);
            end
            if (bus_ack) begin
                bus_wr_req = 1'b0;
                check("skip_after_bus", dut.bus_skipped, 1'b0);
            end
        end
        check("prio_all_served", {dl_req, vid_req, bus_wr_req}, 3'b000);
        dl_req = 1'b0; vid_req = 1'b0; bus_wr_req = 1'b0;
        @(posedge clock); #1;
        check("prio_dl_mem", mem[12'h200], 8'h11);
        check("prio_bus_mem", mem[12'h300], 8'h22);
        check("bus_rdata_hold", bus_rdata, 8'h7E);

        // Reset in access cycle 1 of a write
        bus_wr_req = 1'b1; bus_addr = 21'h00400; bus_wdata = 8'h99;
        @(posedge clock); #1;
        check("pre_rst_we_n", sram_we_n, 1'b0);
        reset_n = 1'b0;
        #1;
        check("mid_rst_we_n", sram_we_n, 1'b1);
        check("mid_rst_oe", sram_oe, 1'b0);
        bus_wr_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("mid_rst_no_ack", {dl_ack, vid_ack, bus_ack}, 3'b000);
        end
        @(posedge clock); #1;
        reset_n = 1'b1;
        check("mid_rst_mem", mem[12'h400], 8'h5C);

        // Normal bus write after reset
        @(posedge clock); #1;
        bus_wr_req = 1'b1; bus_addr = 21'h00400; bus_wdata = 8'h99;
        push(3'b001, 1'b0, 8'h00);
        c0 = cyc; got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clock);
            if (bus_ack) begin
                got = 1'b1;
                check("post_rst_ack_cycle", cyc - c0, 3);
            end
        end
        bus_wr_req = 1'b0;
        check("post_rst_ack_seen", got, 1'b1);
        @(posedge clock); #1;
        check("post_rst_mem", mem[12'h400], 8'h99);
        check("post_rst_ready", bus_ready, 1'b1);

        repeat (3) @(posedge clock);
        check("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
